// File: rtl/cache_burst_pkg.sv
// rtl/cache_burst_pkg.sv - shared types and helpers for the cache burst engine
package cache_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LAT   = 2'd1,
    ST_BURST = 2'd2
  } cb_state_e;

  // Width of a down-counter able to hold the larger of the two CAS latencies
  function automatic int cb_lat_width(input int cl, input int cwl);
    int m;
    m = (cl > cwl) ? cl : cwl;
    return $clog2(m + 1);
  endfunction

  localparam int CB_LAT_W = cb_lat_width(4, 3);

  // Column of beat k: high bits kept, low log2(bl) bits advance and wrap in the block
  function automatic logic [31:0] cb_beat_col(input logic [31:0] col,
                                              input logic [31:0] k,
                                              input int unsigned bl);
    logic [31:0] mask;
    mask = bl - 1;
    return (col & ~mask) | ((col + k) & mask);
  endfunction

endpackage

// File: rtl/cache_data_ram.sv
// rtl/cache_data_ram.sv - single-port synchronous cache data RAM, read-first
module cache_data_ram #(
  parameter int AW = 19,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  // One-cycle registered read; a same-address write returns the old word
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/cache_burst_engine.sv
// rtl/cache_burst_engine.sv - per-channel RD/WR burst engine between DQ pins and cache RAM
module cache_burst_engine #(
  parameter int BGWIDTH  = 2,
  parameter int BAWIDTH  = 2,
  parameter int CHWIDTH  = 5,
  parameter int COLWIDTH = 10,
  parameter int DQWIDTH  = 8,
  parameter int BL       = 8,
  parameter int CL       = 4,
  parameter int CWL      = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [BGWIDTH-1:0]  bg,
  input  logic [BAWIDTH-1:0]  ba,
  input  logic [COLWIDTH-1:0] col,
  input  logic [(1<<BGWIDTH)-1:0][(1<<BAWIDTH)-1:0][CHWIDTH-1:0] cRowId,
  input  logic                hold,
  input  logic [DQWIDTH-1:0]  dq_in,
  output logic [DQWIDTH-1:0]  dq_out,
  output logic                dq_oe,
  output logic                burst_done
);
  import cache_burst_pkg::*;

  localparam int BLW = $clog2(BL);
  localparam int LW  = cb_lat_width(CL, CWL);
  localparam int AW  = BGWIDTH + BAWIDTH + CHWIDTH + COLWIDTH;

  cb_state_e           state_q;
  logic [LW-1:0]       lat_q;
  logic [BLW-1:0]      beat_q;
  logic                wr_q;
  logic [BGWIDTH-1:0]  bg_q;
  logic [BAWIDTH-1:0]  ba_q;
  logic [COLWIDTH-1:0] col_q;
  logic [CHWIDTH-1:0]  crow_q;
  logic                dq_oe_q;
  logic                done_q;

  logic [LW-1:0]       lat_len_d;
  logic [BLW-1:0]      beat_idx_d;
  logic [COLWIDTH-1:0] col_k_d;
  logic [AW-1:0]       ram_addr_d;
  logic                ram_we_d;
  logic [DQWIDTH-1:0]  ram_rdata;

  assign cmd_ready = (state_q == ST_IDLE) && !hold;
  assign lat_len_d = cmd_wr ? LW'(CWL - 1) : LW'(CL - 1);

  // Reads fetch one beat ahead so the RAM's output register lines up with dq_oe
  always_comb begin
    beat_idx_d = '0;
    if (wr_q) beat_idx_d = beat_q;
    else if (state_q == ST_BURST) beat_idx_d = beat_q + 1'b1;
  end

  assign col_k_d    = COLWIDTH'(cb_beat_col(32'(col_q), 32'(beat_idx_d), BL));
  assign ram_addr_d = {bg_q, ba_q, crow_q, col_k_d};
  // Gating with reset_n drops the write in flight on the reset edge
  assign ram_we_d   = reset_n && (state_q == ST_BURST) && wr_q;

  assign dq_out     = dq_oe_q ? ram_rdata : '0;
  assign dq_oe      = dq_oe_q;
  assign burst_done = done_q;

  // Command FSM: latch on accept, count CAS latency, then step through BL beats
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      dq_oe_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            wr_q   <= cmd_wr;
            bg_q   <= bg;
            ba_q   <= ba;
            col_q  <= col;
            crow_q <= cRowId[bg][ba];
            beat_q <= '0;
            if (lat_len_d == '0) begin
              state_q <= ST_BURST;
              dq_oe_q <= !cmd_wr;
            end else begin
              state_q <= ST_LAT;
              lat_q   <= lat_len_d;
            end
          end
        end
        ST_LAT: begin
          if (lat_q == LW'(1)) begin
            state_q <= ST_BURST;
            beat_q  <= '0;
            dq_oe_q <= !wr_q;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        ST_BURST: begin
          if (beat_q == BLW'(BL - 1)) begin
            state_q <= ST_IDLE;
            dq_oe_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  cache_data_ram #(
    .AW(AW),
    .DW(DQWIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we_d),
    .addr_i (ram_addr_d),
    .wdata_i(dq_in),
    .rdata_o(ram_rdata)
  );

endmodule
